// File: rtl/des_word_pager.sv
// Captures a 64-bit DES word and pages it out 16 bits at a time (auto dwell or debounced step); also emits the scan tick.
// Latency: page/valid 1 cycle after load, display 2 cycles; no backpressure. PAGER_SAME_WORD_HOLD_EN makes same-word reloads no-ops.
module des_word_pager #(
  parameter int TICK_DIV    = 100000,
  parameter int DWELL_TICKS = 500,
  parameter int DB_TICKS    = 8
) (
  input  logic        sysclk_125mhz,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] data_in,
  input  logic        auto_en,
  input  logic        step_btn,
  output logic [15:0] display,
  output logic [1:0]  page,
  output logic        valid,
  output logic        tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int BW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE    = CW'(TICK_DIV - 2);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DB_TICKS - 1);

  typedef enum logic [1:0] {IDLE, HOLD, SCROLL} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          btn_s1;
  logic          btn_s2;
  logic          db_lvl;
  logic [BW-1:0] db_run;
  logic [63:0]   word;
  logic [DW-1:0] dwell;
  logic          step_pulse;
  logic          expire;
  logic          do_load;

  // tick is registered one count early so it is high exactly while cnt==TICK_DIV-1
  always_ff @(posedge sysclk_125mhz or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      tick <= (cnt == CNT_PRE);
    end
  end

  always_ff @(posedge sysclk_125mhz or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      db_lvl <= 1'b0;
      db_run <= '0;
    end else begin
      btn_s1 <= step_btn;
      btn_s2 <= btn_s1;
      if (tick) begin
        if (btn_s2 != db_lvl) begin
          if (db_run == DB_LAST) begin
            db_lvl <= btn_s2;
            db_run <= '0;
          end else begin
            db_run <= db_run + BW'(1);
          end
        end else begin
          db_run <= '0;
        end
      end
    end
  end

  // Pulse coincides with the tick that accepts a press, so it can collide with dwell expiry
  assign step_pulse = tick && btn_s2 && !db_lvl && (db_run == DB_LAST);
  assign expire     = tick && (dwell == DWELL_LAST);

`ifdef PAGER_SAME_WORD_HOLD_EN
  assign do_load = load && !(valid && (data_in == word));
`else
  assign do_load = load;
`endif

  always_ff @(posedge sysclk_125mhz or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      word    <= '0;
      page    <= '0;
      dwell   <= '0;
      valid   <= 1'b0;
      display <= '0;
    end else begin
      display <= word[{page, 4'b0000} +: 16];
      if (do_load) begin
        word  <= data_in;
        page  <= '0;
        dwell <= '0;
        valid <= 1'b1;
        state <= auto_en ? SCROLL : HOLD;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          HOLD: begin
            if (step_pulse) page <= page + 2'd1;
            if (auto_en) begin
              state <= SCROLL;
              dwell <= '0;
            end
          end
          SCROLL: begin
            if (!auto_en) begin
              state <= HOLD;
              if (step_pulse) page <= page + 2'd1;
            end else if (step_pulse || expire) begin
              page  <= page + 2'd1;
              dwell <= '0;
            end else if (tick) begin
              dwell <= dwell + DW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/des_word_pager.md
Name: des_word_pager

Overview:
- Sits between the DES core output and the 7-segment driver. Captures a 64-bit word (cyphertext, plaintext or key) on a load strobe.
- Presents one 16-bit page of that word at a time. Pages advance either automatically on a dwell timer or manually from a debounced step button.
- Also produces the divided one-cycle tick used as the display scan clock enable. This replaces the free-running counter and manual switch paging at top level.

Parameters:
- TICK_DIV, 100000: sysclk_125mhz cycles per tick. Must be ≥2.
- DWELL_TICKS, 500: ticks a page is shown in auto-scroll mode. Must be ≥1.
- DB_TICKS, 8: consecutive equal tick-sampled values needed to accept a new step_btn level. Must be ≥1.

Ports:
- sysclk_125mhz  in   1   system clock; all state on its rising edge
- rst            in   1   asynchronous, active-high reset
- load           in   1   one-cycle strobe: capture data_in
- data_in        in   64  word to capture
- auto_en        in   1   1 = auto-scroll, 0 = hold/manual
- step_btn       in   1   raw, asynchronous push-button
- display        out  16  selected page, registered
- page           out  2   current page index (0 = bits 15:0 … 3 = bits 63:48)
- valid          out  1   a word has been captured since reset
- tick           out  1   one-cycle pulse every TICK_DIV clocks

Behaviour:
- Reset values (asynchronous, active-high):
  - All registers cleared.
  - display=0, page=0, valid=0, tick=0.
  - Prescaler=0, dwell=0, debounce state=0 (button released).
  - FSM=IDLE.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick=1 in exactly the cycle count==TICK_DIV-1. It runs in every state, including IDLE.
- Step input path:
  - 2-flop synchroniser on step_btn.
  - The synchronised level is sampled only on tick cycles. The debounced level flips after DB_TICKS consecutive samples that differ from the current debounced level. Any sample equal to the current level resets the run count.
  - A rising edge of the debounced level gives a one-cycle step pulse. Release produces no pulse.
- FSM states and transitions:
  - IDLE: valid=0, display=0. Step pulses and ticks are ignored. load → HOLD if auto_en=0, else SCROLL.
  - HOLD: page is fixed. A step pulse advances page by 1, wrapping 3→0. auto_en=1 → SCROLL with dwell cleared.
  - SCROLL: dwell increments on each tick. When tick occurs with dwell==DWELL_TICKS-1, page advances (wrapping 3→0) and dwell clears. A step pulse advances page immediately and clears dwell. auto_en=0 → HOLD with page kept.
- Load:
  - In any state: word<=data_in, page<=0, dwell<=0, valid<=1.
  - Next state is chosen from auto_en in the same cycle.
  - Load has priority over a simultaneous step pulse or dwell expiry; both are discarded.
- Simultaneous step pulse and dwell expiry in SCROLL: page advances once only, dwell clears.
- Output latency:
  - display = word[16*page +: 16], registered. It updates 1 cycle after the page or word register changes.
  - Load at cycle N gives the new display at N+2: word captured at N+1, display registered at N+2.
  - page and valid are direct register outputs, updating at N+1.
- Reset mid-operation returns everything to reset values immediately. No partial page or dwell state survives.

Optional Feature:
- Macro name: PAGER_SAME_WORD_HOLD_EN.
- When defined: a load whose data_in equals the currently held word while valid=1 is a no-op. page, dwell and state are unchanged, so repeated strobes of a steady DES result do not restart scrolling. This needs one 64-bit equality compare.
- When not defined: every load resets page and dwell as described above.

Test Plan (TICK_DIV=4, DWELL_TICKS=3, DB_TICKS=2):
- Reset, then run 12 clocks with no stimulus → valid=0, display=16'h0000, FSM in IDLE; tick pulses at clocks 4, 8, 12.
- auto_en=0, load data_in=64'h2579DB866C0F528C → page=0 after 1 clock, display=16'h528C after 2 clocks. Hold step_btn high for ≥3 ticks → exactly one advance to page=1, display=16'h6C0F. Holding longer produces no further advance.
- auto_en=1 after loading 64'h433E4529462A4A62 → display sequence 4A62, 462A, 4529, 433E, 4A62 with 3 ticks (12 clocks) per page, wrapping 3→0.
- In SCROLL, step pulse and dwell expiry in the same cycle → page advances by 1 only. Then load 64'hFFFF0000FFFF0000 together with another step pulse → page=0, display=16'h0000, step ignored.
- step_btn glitch high for 1 tick sample, then low → no page change. Assert rst mid-SCROLL → all outputs 0 asynchronously, before the next clock edge.
- With PAGER_SAME_WORD_HOLD_EN: reload the identical word at page=2 → page stays 2. Without the macro: the same reload gives page=0.
